// File: rtl/turn_arbiter.sv
// Turn sequencer for a shared tic-tac-toe board memory: clears the board, then
// grants the single write port to whichever player holds the turn.
module turn_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        start,
    input  logic        isPlayer1Start,
    input  logic        p1Req,
    input  logic [3:0]  p1Cell,
    output logic        p1Ack,
    output logic        p1Nack,
    input  logic        p2Req,
    input  logic [3:0]  p2Cell,
    output logic        p2Ack,
    output logic        p2Nack,
    input  logic [17:0] gBoard,
    input  logic        gameIsDone,
    input  logic [1:0]  winner,
    output logic [3:0]  addr,
    output logic [1:0]  cellState,
    output logic        we,
    output logic        activePlayer,
    output logic [3:0]  moveCount,
    output logic        timeoutPulse,
    output logic        gameOver,
    output logic [1:0]  result,
    output logic [2:0]  outputState
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_TURN   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_SETTLE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_cell;
    logic [3:0]    r_addr;
    logic [1:0]    r_cell_state;
    logic          r_we;
    logic          r_active;
    logic [3:0]    r_move_count;
    logic [1:0]    r_result;

    logic          w_req;
    logic [3:0]    w_req_cell;
    logic [1:0]    w_cell_bits;
    logic          w_illegal;
    logic          w_timeout;

    // Handshake: a player holds Req (with a stable Cell) until it sees a
    // one-cycle Ack (move written) or Nack (move rejected); only the active
    // player's Req is ever looked at, the other one simply waits.
    assign w_req      = r_active ? p1Req  : p2Req;
    assign w_req_cell = r_active ? p1Cell : p2Cell;

    // Out-of-range cells read as occupied so one test covers both rejections.
    always_comb begin
        w_cell_bits = 2'b11;
        case (r_cell)
            4'd0:    w_cell_bits = gBoard[1:0];
            4'd1:    w_cell_bits = gBoard[3:2];
            4'd2:    w_cell_bits = gBoard[5:4];
            4'd3:    w_cell_bits = gBoard[7:6];
            4'd4:    w_cell_bits = gBoard[9:8];
            4'd5:    w_cell_bits = gBoard[11:10];
            4'd6:    w_cell_bits = gBoard[13:12];
            4'd7:    w_cell_bits = gBoard[15:14];
            4'd8:    w_cell_bits = gBoard[17:16];
            default: w_cell_bits = 2'b11;
        endcase
    end

    assign w_illegal = (w_cell_bits != 2'b00);
    assign w_timeout = (r_state == S_TURN) && !w_req && !start && (r_timer == TIMER_LAST);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_cell       <= 4'd0;
            r_addr       <= 4'd0;
            r_cell_state <= 2'b00;
            r_we         <= 1'b0;
            r_active     <= 1'b1;
            r_move_count <= 4'd0;
            r_result     <= 2'b00;
        end else if (start && (r_state != S_CLEAR)) begin
            r_state      <= S_CLEAR;
            r_timer      <= '0;
            r_addr       <= 4'd0;
            r_cell_state <= 2'b00;
            r_we         <= 1'b1;
            r_move_count <= 4'd0;
            r_result     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_CLEAR: begin
                    if (r_addr == 4'd8) begin
                        r_we     <= 1'b0;
                        r_active <= isPlayer1Start;
                        r_timer  <= '0;
                        r_state  <= S_TURN;
                    end else begin
                        r_addr <= r_addr + 4'd1;
                    end
                end
                S_TURN: begin
                    if (w_req) begin
                        r_cell  <= w_req_cell;
                        r_timer <= '0;
                        r_state <= S_CHECK;
                    end else if (r_timer == TIMER_LAST) begin
                        r_active <= ~r_active;
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_state <= S_TURN;
                    end else begin
                        r_we         <= 1'b1;
                        r_addr       <= r_cell;
                        r_cell_state <= r_active ? 2'b11 : 2'b10;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    if (r_move_count < 4'd9)
                        r_move_count <= r_move_count + 4'd1;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (gameIsDone) begin
                        r_result <= winner;
                        r_state  <= S_DONE;
                    end else begin
                        r_active <= ~r_active;
                        r_timer  <= '0;
                        r_state  <= S_TURN;
                    end
                end
                S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign p1Ack        = (r_state == S_WRITE) && r_active;
    assign p2Ack        = (r_state == S_WRITE) && !r_active;
    assign p1Nack       = (r_state == S_CHECK) && w_illegal && r_active;
    assign p2Nack       = (r_state == S_CHECK) && w_illegal && !r_active;
    assign timeoutPulse = w_timeout;
    assign gameOver     = (r_state == S_DONE);
    assign addr         = r_addr;
    assign cellState    = r_cell_state;
    assign we           = r_we;
    assign activePlayer = r_active;
    assign moveCount    = r_move_count;
    assign result       = r_result;
    assign outputState  = r_state;

endmodule

// File: tb/tb_turn_arbiter.sv
// Bench for turn_arbiter: a board memory and win logic sit around the DUT, and
// a move-level model predicts every response.
module tb_turn_arbiter;

    localparam int T = 16;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        isPlayer1Start = 1'b0;
    logic        p1Req = 1'b0;
    logic [3:0]  p1Cell = 4'd0;
    logic        p2Req = 1'b0;
    logic [3:0]  p2Cell = 4'd0;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic [1:0]  winner;
    logic        p1Ack, p1Nack, p2Ack, p2Nack;
    logic [3:0]  addr;
    logic [1:0]  cellState;
    logic        we;
    logic        activePlayer;
    logic [3:0]  moveCount;
    logic        timeoutPulse;
    logic        gameOver;
    logic [1:0]  result;
    logic [2:0]  outputState;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] mem_vec = '0;
    logic [1:0]  exp_board [9];
    logic        exp_active;
    logic [3:0]  exp_count;
    logic        exp_done;
    logic [1:0]  exp_result;
    logic [3:0]  exp_q [$];

    turn_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .ph1(ph1), .reset(reset), .start(start), .isPlayer1Start(isPlayer1Start),
        .p1Req(p1Req), .p1Cell(p1Cell), .p1Ack(p1Ack), .p1Nack(p1Nack),
        .p2Req(p2Req), .p2Cell(p2Cell), .p2Ack(p2Ack), .p2Nack(p2Nack),
        .gBoard(gBoard), .gameIsDone(gameIsDone), .winner(winner),
        .addr(addr), .cellState(cellState), .we(we), .activePlayer(activePlayer),
        .moveCount(moveCount), .timeoutPulse(timeoutPulse), .gameOver(gameOver),
        .result(result), .outputState(outputState)
    );

    // clock / reset
    always #5 ph1 = ~ph1;

    // board memory
    always @(posedge ph1) begin
        if (we && addr <= 4'd8)
            mem_vec[{addr, 1'b0} +: 2] <= cellState;
    end

    function automatic logic [1:0] line3(input logic [17:0] b, input int a, input int c, input int d);
        logic [1:0] x, y, z;
        x = b[2*a +: 2];
        y = b[2*c +: 2];
        z = b[2*d +: 2];
        return (x != 2'b00 && x == y && y == z) ? x : 2'b00;
    endfunction

    function automatic logic [1:0] judge(input logic [17:0] b);
        int t [24];
        logic [1:0] r;
        logic full;
        t = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
        r = 2'b00;
        for (int k = 0; k < 8; k++)
            if (r == 2'b00) r = line3(b, t[3*k], t[3*k+1], t[3*k+2]);
        full = 1'b1;
        for (int k = 0; k < 9; k++)
            if (b[2*k +: 2] == 2'b00) full = 1'b0;
        if (r == 2'b00 && full) r = 2'b01;
        return r;
    endfunction

    function automatic logic [17:0] pack_board();
        logic [17:0] v;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = exp_board[i];
        return v;
    endfunction

    // win logic
    assign gBoard = mem_vec;
    always_comb begin
        winner     = judge(mem_vec);
        gameIsDone = (winner != 2'b00);
    end

    // driver tasks
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge ph1);
        n_tests++;
        if ({we, addr, cellState, outputState} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_port: we/addr/cs/state=%b %h %b %0d want all zero", we, addr, cellState, outputState);
        end
        n_tests++;
        if ({activePlayer, moveCount, result, gameOver, timeoutPulse} !== {1'b1, 4'd0, 2'b00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_status: act=%b cnt=%0d res=%b go=%b to=%b want 1 0 00 0 0",
                     activePlayer, moveCount, result, gameOver, timeoutPulse);
        end
        n_tests++;
        if ({p1Ack, p1Nack, p2Ack, p2Nack} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_handshake: acks/nacks=%b want 0000", {p1Ack, p1Nack, p2Ack, p2Nack});
        end
        reset = 1'b1;
        @(negedge ph1);
        n_tests++;
        if (outputState !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d want 0", outputState);
        end
    endtask

    task automatic start_game(input logic p1first);
        isPlayer1Start = p1first;
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(4'(i));
        for (int i = 0; i < 9; i++) begin
            logic [3:0] ea;
            ea = exp_q.pop_front();
            n_tests++;
            if ({outputState, we, cellState, addr, moveCount, result} !== {3'd1, 1'b1, 2'b00, ea, 4'd0, 2'b00}) begin
                n_fail++;
                $display("FAIL clear_sweep: st=%0d we=%b cs=%b addr=%0d cnt=%0d res=%b want 1 1 00 %0d 0 00",
                         outputState, we, cellState, addr, moveCount, result, ea);
            end
            @(negedge ph1);
        end
        n_tests++;
        if ({outputState, activePlayer, we, moveCount, gameOver} !== {3'd2, p1first, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_to_turn: st=%0d act=%b we=%b cnt=%0d go=%b want 2 %b 0 0 0",
                     outputState, activePlayer, we, moveCount, gameOver, p1first);
        end
        for (int i = 0; i < 9; i++) exp_board[i] = 2'b00;
        exp_active = p1first;
        exp_count  = 4'd0;
        exp_done   = 1'b0;
        exp_result = 2'b00;
    endtask

    task automatic do_move(input logic [3:0] c);
        logic p, legal, got;
        int lat;
        logic [1:0] mine, oth, res;
        p = exp_active;
        legal = 1'b0;
        if (c <= 4'd8) legal = (exp_board[c] == 2'b00);
        if (p) begin p1Req = 1'b1; p1Cell = c; end
        else   begin p2Req = 1'b1; p2Cell = c; end
        got = 1'b0;
        lat = 0;
        mine = 2'b00;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(negedge ph1);
            mine = p ? {p1Ack, p1Nack} : {p2Ack, p2Nack};
            oth  = p ? {p2Ack, p2Nack} : {p1Ack, p1Nack};
            n_tests++;
            if ({oth, timeoutPulse} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_channel_quiet: other ack/nack=%b timeout=%b want 00 0", oth, timeoutPulse);
            end
            if (mine != 2'b00) begin got = 1'b1; lat = i; end
        end
        n_tests++;
        if (!got || mine !== (legal ? 2'b10 : 2'b01) || lat != (legal ? 2 : 1)) begin
            n_fail++;
            $display("FAIL move_response: p%0d cell %0d ack/nack=%b after %0d cycles want %b after %0d",
                     p ? 1 : 2, c, mine, lat, legal ? 2'b10 : 2'b01, legal ? 2 : 1);
        end
        n_tests++;
        if (legal) begin
            if ({we, addr, cellState} !== {1'b1, c, p ? 2'b11 : 2'b10}) begin
                n_fail++;
                $display("FAIL write_port: we=%b addr=%0d cs=%b want 1 %0d %b", we, addr, cellState, c, p ? 2'b11 : 2'b10);
            end
        end else if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_no_write: we=%b want 0", we);
        end
        p1Req = 1'b0;
        p2Req = 1'b0;
        if (legal) begin
            exp_board[c] = p ? 2'b11 : 2'b10;
            if (exp_count < 4'd9) exp_count = exp_count + 4'd1;
            @(negedge ph1);
            n_tests++;
            if ({outputState, we, moveCount} !== {3'd5, 1'b0, exp_count}) begin
                n_fail++;
                $display("FAIL settle: st=%0d we=%b cnt=%0d want 5 0 %0d", outputState, we, moveCount, exp_count);
            end
            n_tests++;
            if (mem_vec !== pack_board()) begin
                n_fail++;
                $display("FAIL board_contents: got %h want %h", mem_vec, pack_board());
            end
            res = judge(pack_board());
            @(negedge ph1);
            n_tests++;
            if (res != 2'b00) begin
                exp_done   = 1'b1;
                exp_result = res;
                if ({outputState, gameOver, result} !== {3'd6, 1'b1, res}) begin
                    n_fail++;
                    $display("FAIL enter_done: st=%0d go=%b res=%b want 6 1 %b", outputState, gameOver, result, res);
                end
            end else begin
                exp_active = !p;
                if ({outputState, activePlayer, gameOver} !== {3'd2, !p, 1'b0}) begin
                    n_fail++;
                    $display("FAIL next_turn: st=%0d act=%b go=%b want 2 %b 0", outputState, activePlayer, gameOver, !p);
                end
            end
        end else begin
            @(negedge ph1);
            n_tests++;
            if ({outputState, moveCount, activePlayer} !== {3'd2, exp_count, p}) begin
                n_fail++;
                $display("FAIL after_nack: st=%0d cnt=%0d act=%b want 2 %0d %b",
                         outputState, moveCount, activePlayer, exp_count, p);
            end
        end
    endtask

    task automatic test_first_move();
        start_game(1'b1);
        do_move(4'd4);
    endtask

    task automatic test_nack();
        int nacks;
        p1Req = 1'b1;
        p1Cell = 4'd0;
        do_move(4'd4);
        p1Req = 1'b1;
        do_move(4'd9);
        p1Req = 1'b1;
        p2Req = 1'b1;
        p2Cell = 4'd9;
        nacks = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge ph1);
            if (p2Nack === 1'b1) nacks++;
            n_tests++;
            if ({p1Ack, p1Nack, p2Ack, we} !== 4'b0000) begin
                n_fail++;
                $display("FAIL held_req_quiet: p1ack p1nack p2ack we=%b want 0000", {p1Ack, p1Nack, p2Ack, we});
            end
        end
        p1Req = 1'b0;
        p2Req = 1'b0;
        n_tests++;
        if (nacks != 3) begin
            n_fail++;
            $display("FAIL held_nack_repeat: %0d nacks in 6 cycles want 3", nacks);
        end
        @(negedge ph1);
        n_tests++;
        if ({outputState, moveCount, activePlayer} !== {3'd2, exp_count, exp_active}) begin
            n_fail++;
            $display("FAIL held_nack_end: st=%0d cnt=%0d act=%b want 2 %0d %b",
                     outputState, moveCount, activePlayer, exp_count, exp_active);
        end
    endtask

    task automatic test_timeout();
        int pulses, at;
        start_game(1'b1);
        pulses = 0;
        at = 0;
        for (int i = 1; i <= T; i++) begin
            if (timeoutPulse === 1'b1) begin pulses++; at = i; end
            @(negedge ph1);
        end
        n_tests++;
        if (pulses != 1 || at != T) begin
            n_fail++;
            $display("FAIL timeout_pulse: %0d pulses, last at cycle %0d want 1 at %0d", pulses, at, T);
        end
        n_tests++;
        if ({activePlayer, timeoutPulse, outputState} !== {1'b0, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL timeout_flip: act=%b to=%b st=%0d want 0 0 2", activePlayer, timeoutPulse, outputState);
        end
        start_game(1'b0);
        repeat (T - 1) @(negedge ph1);
        n_tests++;
        if (timeoutPulse !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_cycle_reached: to=%b want 1", timeoutPulse);
        end
        do_move(4'd0);
    endtask

    task automatic test_win();
        start_game(1'b1);
        do_move(4'd0);
        do_move(4'd3);
        do_move(4'd1);
        do_move(4'd4);
        do_move(4'd2);
        p1Req = 1'b1; p1Cell = 4'd5;
        p2Req = 1'b1; p2Cell = 4'd6;
        for (int i = 0; i < 5; i++) begin
            @(negedge ph1);
            n_tests++;
            if ({p1Ack, p1Nack, p2Ack, p2Nack, we, outputState, gameOver, result} !==
                {4'b0000, 1'b0, 3'd6, 1'b1, exp_result}) begin
                n_fail++;
                $display("FAIL done_ignores_req: hs=%b we=%b st=%0d go=%b res=%b want 0000 0 6 1 %b",
                         {p1Ack, p1Nack, p2Ack, p2Nack}, we, outputState, gameOver, result, exp_result);
            end
        end
        p1Req = 1'b0;
        p2Req = 1'b0;
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
        n_tests++;
        if ({outputState, we, addr, gameOver} !== {3'd1, 1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL done_restart: st=%0d we=%b addr=%0d go=%b want 1 1 0 0", outputState, we, addr, gameOver);
        end
        repeat (9) @(negedge ph1);
        n_tests++;
        if ({outputState, moveCount, result} !== {3'd2, 4'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL restart_turn: st=%0d cnt=%0d res=%b want 2 0 00", outputState, moveCount, result);
        end
    endtask

    task automatic test_random();
        for (int g = 0; g < 4; g++) begin
            int moves;
            start_game(1'($urandom_range(0, 1)));
            moves = 0;
            while (!exp_done && moves < 40) begin
                logic [3:0] c;
                int empties [$];
                empties.delete();
                for (int i = 0; i < 9; i++)
                    if (exp_board[i] == 2'b00) empties.push_back(i);
                if ($urandom_range(0, 3) == 0)
                    c = 4'($urandom_range(0, 15));
                else
                    c = 4'(empties[$urandom_range(0, empties.size() - 1)]);
                repeat ($urandom_range(0, 3)) @(negedge ph1);
                do_move(c);
                moves++;
            end
            n_tests++;
            if ({outputState, gameOver, result} !== {3'd6, 1'b1, exp_result} || mem_vec !== pack_board()) begin
                n_fail++;
                $display("FAIL random_game_end: st=%0d go=%b res=%b board=%h want 6 1 %b %h",
                         outputState, gameOver, result, mem_vec, exp_result, pack_board());
            end
        end
    endtask

    task automatic test_reset_mid_write();
        start_game(1'b1);
        p1Req = 1'b1;
        p1Cell = 4'd5;
        repeat (2) @(negedge ph1);
        n_tests++;
        if ({we, outputState} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL pre_reset_write: we=%b st=%0d want 1 4", we, outputState);
        end
        p1Req = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({we, addr, cellState, outputState, moveCount, p1Ack, activePlayer, result, gameOver} !==
            {1'b0, 4'd0, 2'b00, 3'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: we=%b addr=%0d cs=%b st=%0d cnt=%0d ack=%b act=%b res=%b go=%b want 0 0 00 0 0 0 1 00 0",
                     we, addr, cellState, outputState, moveCount, p1Ack, activePlayer, result, gameOver);
        end
        @(negedge ph1);
        reset = 1'b1;
        @(negedge ph1);
        n_tests++;
        if ({outputState, we} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_idle: st=%0d we=%b want 0 0", outputState, we);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_move();
        test_nack();
        test_timeout();
        test_win();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
